// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline: inter-stage register control codes,
// hazard sequencer state encoding and the load-use detection helper.
package mips_pipe_pkg;

    localparam logic [1:0] CTL_FLUSH = 2'b00;
    localparam logic [1:0] CTL_ADV   = 2'b01;
    localparam logic [1:0] CTL_HOLD  = 2'b10;

    typedef enum logic [1:0] {
        S_RUN      = 2'b00,
        S_LU       = 2'b01,
        S_MEM_WAIT = 2'b10
    } hz_state_e;

    // A load in EX whose destination is read by the instruction in ID; r0 never stalls.
    function automatic logic load_use(input logic       mem_read,
                                      input logic       reg_write,
                                      input logic [4:0] wr_addr,
                                      input logic [4:0] rs_addr,
                                      input logic [4:0] rt_addr,
                                      input logic       uses_rt);
        return mem_read & reg_write & (wr_addr != 5'd0) &
               ((wr_addr == rs_addr) | (uses_rt & (wr_addr == rt_addr)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard sequencer (slave).
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs_addr;
    logic [4:0]       id_rt_addr;
    logic             id_uses_rt;
    logic             id_jump;
    logic             ex_mem_read;
    logic             ex_reg_write;
    logic [4:0]       ex_wr_addr;
    logic             ex_branch_taken;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_en;
    logic             pc_sel_branch;
    logic [1:0]       if_id_ctl;
    logic [1:0]       id_ex_ctl;
    logic [1:0]       ex_mem_ctl;
    logic [1:0]       mem_wb_ctl;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output id_rs_addr, id_rt_addr, id_uses_rt, id_jump,
        output ex_mem_read, ex_reg_write, ex_wr_addr, ex_branch_taken,
        output dmem_req, dmem_ready,
        input  pc_en, pc_sel_branch, if_id_ctl, id_ex_ctl, ex_mem_ctl, mem_wb_ctl,
        input  mem_err, stall_cycles, flush_events
    );

    modport slave (
        input  id_rs_addr, id_rt_addr, id_uses_rt, id_jump,
        input  ex_mem_read, ex_reg_write, ex_wr_addr, ex_branch_taken,
        input  dmem_req, dmem_ready,
        output pc_en, pc_sel_branch, if_id_ctl, id_ex_ctl, ex_mem_ctl, mem_wb_ctl,
        output mem_err, stall_cycles, flush_events
    );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q;

    // Count register with saturation at the maximum value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= {CNT_W{1'b0}};
        end else if (inc && (count_q != CNT_MAX)) begin
            count_q <= count_q + CNT_W'(1);
        end else begin
            count_q <= count_q;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: drives stage-register control codes and
// the PC enable for load-use stalls, branch/jump flushes and dmem waits with timeout.
module pipeline_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  hz
);
    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    hz_state_e      state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           mem_err_q, mem_err_d;

    logic       pc_en_s, pc_sel_s, flush_inc_s, stall_inc_s, lu_s, mem_stall_s;
    logic [1:0] if_id_s, id_ex_s, ex_mem_s, mem_wb_s;

    assign lu_s = load_use(hz.ex_mem_read, hz.ex_reg_write, hz.ex_wr_addr,
                           hz.id_rs_addr, hz.id_rt_addr, hz.id_uses_rt);
    assign mem_stall_s = hz.dmem_req & ~hz.dmem_ready;

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_RUN;
            wait_cnt_q <= {WCW{1'b0}};
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // Next-state and control-code decode; outputs follow state and inputs directly.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        pc_en_s     = 1'b1;
        pc_sel_s    = 1'b0;
        if_id_s     = CTL_ADV;
        id_ex_s     = CTL_ADV;
        ex_mem_s    = CTL_ADV;
        mem_wb_s    = CTL_ADV;
        flush_inc_s = 1'b0;
        if (reset) begin
            pc_en_s    = 1'b0;
            if_id_s    = CTL_FLUSH;
            id_ex_s    = CTL_FLUSH;
            ex_mem_s   = CTL_FLUSH;
            mem_wb_s   = CTL_FLUSH;
            state_d    = S_RUN;
            wait_cnt_d = {WCW{1'b0}};
            mem_err_d  = 1'b0;
        end else begin
            case (state_q)
                S_RUN, S_LU: begin
                    if (mem_stall_s) begin
                        pc_en_s    = 1'b0;
                        if_id_s    = CTL_HOLD;
                        id_ex_s    = CTL_HOLD;
                        ex_mem_s   = CTL_HOLD;
                        mem_wb_s   = CTL_FLUSH;
                        state_d    = S_MEM_WAIT;
                        wait_cnt_d = WCW'(1);
                    end else if (hz.ex_branch_taken) begin
                        pc_sel_s    = 1'b1;
                        if_id_s     = CTL_FLUSH;
                        id_ex_s     = CTL_FLUSH;
                        state_d     = S_RUN;
                        flush_inc_s = 1'b1;
                    end else if (lu_s && (state_q == S_RUN)) begin
                        // S_LU skips this check so each load costs exactly one bubble.
                        pc_en_s = 1'b0;
                        if_id_s = CTL_HOLD;
                        id_ex_s = CTL_FLUSH;
                        state_d = S_LU;
                    end else if (hz.id_jump) begin
                        if_id_s     = CTL_FLUSH;
                        state_d     = S_RUN;
                        flush_inc_s = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_MEM_WAIT: begin
                    if (hz.dmem_ready) begin
                        state_d    = S_RUN;
                        wait_cnt_d = {WCW{1'b0}};
                    end else if (wait_cnt_q == WCW'(MEM_TIMEOUT)) begin
                        mem_err_d  = 1'b1;
                        state_d    = S_RUN;
                        wait_cnt_d = {WCW{1'b0}};
                    end else begin
                        pc_en_s    = 1'b0;
                        if_id_s    = CTL_HOLD;
                        id_ex_s    = CTL_HOLD;
                        ex_mem_s   = CTL_HOLD;
                        mem_wb_s   = CTL_FLUSH;
                        wait_cnt_d = wait_cnt_q + WCW'(1);
                    end
                end
                default: begin
                    state_d    = S_RUN;
                    wait_cnt_d = {WCW{1'b0}};
                end
            endcase
        end
    end

    assign stall_inc_s = ~pc_en_s & ~reset;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc_s),
        .count (hz.stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc_s),
        .count (hz.flush_events)
    );

    assign hz.pc_en         = pc_en_s;
    assign hz.pc_sel_branch = pc_sel_s;
    assign hz.if_id_ctl     = if_id_s;
    assign hz.id_ex_ctl     = id_ex_s;
    assign hz.ex_mem_ctl    = ex_mem_s;
    assign hz.mem_wb_ctl    = mem_wb_s;
    assign hz.mem_err       = mem_err_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Vector-table and scoreboard bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipeline_hazard_ctrl;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   vec_no;

    pipeline_hazard_ctrl_if #(.CNT_W(4)) hz();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl packs {if_id, id_ex, ex_mem, mem_wb}; counters are the values visible in that cycle
    typedef struct packed {
        logic [7:0] id;
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urt;
        logic       jmp;
        logic       mrd;
        logic       rwr;
        logic [4:0] wa;
        logic       br;
        logic       req;
        logic       rdy;
        logic       e_pc;
        logic       e_sel;
        logic [7:0] e_ctl;
        logic       e_err;
        logic [3:0] e_stall;
        logic [3:0] e_flush;
    } vec_t;

    vec_t table_q[$];
    vec_t sb[$];

    function automatic vec_t mkv(input int rst, input int rs, input int rt, input int urt,
                                 input int jmp, input int mrd, input int rwr, input int wa,
                                 input int br, input int req, input int rdy,
                                 input int e_pc, input int e_sel, input int e_ctl,
                                 input int e_err, input int e_stall, input int e_flush);
        vec_t v;
        v.id      = 8'd0;
        v.rst     = 1'(rst);
        v.rs      = 5'(rs);
        v.rt      = 5'(rt);
        v.urt     = 1'(urt);
        v.jmp     = 1'(jmp);
        v.mrd     = 1'(mrd);
        v.rwr     = 1'(rwr);
        v.wa      = 5'(wa);
        v.br      = 1'(br);
        v.req     = 1'(req);
        v.rdy     = 1'(rdy);
        v.e_pc    = 1'(e_pc);
        v.e_sel   = 1'(e_sel);
        v.e_ctl   = 8'(e_ctl);
        v.e_err   = 1'(e_err);
        v.e_stall = 4'(e_stall);
        v.e_flush = 4'(e_flush);
        return v;
    endfunction

    task automatic add(input vec_t v);
        table_q.push_back(v);
    endtask

    task automatic chk(input int idx, input string fld, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL vec%0d %s: got %h want %h", idx, fld, act, exp);
        end
    endtask

    task automatic check_out();
        vec_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: got empty queue want one entry");
        end else begin
            e = sb.pop_front();
            chk(int'(e.id), "pc_en",         {7'd0, hz.pc_en},         {7'd0, e.e_pc});
            chk(int'(e.id), "pc_sel_branch", {7'd0, hz.pc_sel_branch}, {7'd0, e.e_sel});
            chk(int'(e.id), "ctl",           {hz.if_id_ctl, hz.id_ex_ctl, hz.ex_mem_ctl, hz.mem_wb_ctl}, e.e_ctl);
            chk(int'(e.id), "mem_err",       {7'd0, hz.mem_err},       {7'd0, e.e_err});
            chk(int'(e.id), "stall_cycles",  {4'd0, hz.stall_cycles},  {4'd0, e.e_stall});
            chk(int'(e.id), "flush_events",  {4'd0, hz.flush_events},  {4'd0, e.e_flush});
        end
    endtask

    task automatic step(input vec_t v);
        vec_t w;
        @(negedge clk);
        reset              = v.rst;
        hz.id_rs_addr      = v.rs;
        hz.id_rt_addr      = v.rt;
        hz.id_uses_rt      = v.urt;
        hz.id_jump         = v.jmp;
        hz.ex_mem_read     = v.mrd;
        hz.ex_reg_write    = v.rwr;
        hz.ex_wr_addr      = v.wa;
        hz.ex_branch_taken = v.br;
        hz.dmem_req        = v.req;
        hz.dmem_ready      = v.rdy;
        w    = v;
        w.id = 8'(vec_no);
        vec_no++;
        sb.push_back(w);
        #2;
        check_out();
    endtask

    initial begin
        vec_t v;
        int   nst;
        total = 0;
        bad   = 0;
        vec_no = 0;
        reset = 1'b1;
        hz.id_rs_addr = 5'd0;      hz.id_rt_addr = 5'd0;   hz.id_uses_rt = 1'b0;
        hz.id_jump = 1'b0;         hz.ex_mem_read = 1'b0;  hz.ex_reg_write = 1'b0;
        hz.ex_wr_addr = 5'd0;      hz.ex_branch_taken = 1'b0;
        hz.dmem_req = 1'b0;        hz.dmem_ready = 1'b0;

        //        rst rs rt urt jmp mrd rwr wa br req rdy | pc sel ctl  err st fl
        // reset and idle
        add(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 'h00, 0, 0, 0));
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 'h55, 0, 0, 0));
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 'h55, 0, 0, 0));
        // load-use on rs, one bubble per S_LU visit, then rt and non-hazard variants
        add(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 'h00, 0, 0, 0));
        add(mkv(0, 5, 0, 0, 0, 1, 1, 5, 0, 0, 0,   0, 0, 'h85, 0, 0, 0));
        add(mkv(0, 5, 0, 0, 0, 1, 1, 5, 0, 0, 0,   1, 0, 'h55, 0, 1, 0));
        add(mkv(0, 5, 0, 0, 0, 1, 1, 5, 0, 0, 0,   0, 0, 'h85, 0, 1, 0));
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 'h55, 0, 2, 0));
        add(mkv(0, 3, 7, 1, 0, 1, 1, 7, 0, 0, 0,   0, 0, 'h85, 0, 2, 0));
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 'h55, 0, 3, 0));
        add(mkv(0, 3, 7, 0, 0, 1, 1, 7, 0, 0, 0,   1, 0, 'h55, 0, 3, 0));
        add(mkv(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0,   1, 0, 'h55, 0, 3, 0));
        add(mkv(0, 5, 0, 0, 0, 1, 0, 5, 0, 0, 0,   1, 0, 'h55, 0, 3, 0));
        add(mkv(0, 5, 0, 0, 0, 0, 1, 5, 0, 0, 0,   1, 0, 'h55, 0, 3, 0));
        // branch beats load-use and leaves the FSM in S_RUN
        add(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 'h00, 0, 0, 0));
        add(mkv(0, 5, 0, 0, 0, 1, 1, 5, 1, 0, 0,   1, 1, 'h05, 0, 0, 0));
        add(mkv(0, 5, 0, 0, 0, 1, 1, 5, 0, 0, 0,   0, 0, 'h85, 0, 0, 1));
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 'h55, 0, 1, 1));
        // dmem wait of three cycles, then ready
        add(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 'h00, 0, 0, 0));
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 'hA8, 0, 0, 0));
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 'hA8, 0, 1, 0));
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 'hA8, 0, 2, 0));
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,   1, 0, 'h55, 0, 3, 0));
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 'h55, 0, 3, 0));
        // jump deferred by load-use, plain jump, dmem wait masking branch/jump
        add(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 'h00, 0, 0, 0));
        add(mkv(0, 5, 0, 0, 1, 1, 1, 5, 0, 0, 0,   0, 0, 'h85, 0, 0, 0));
        add(mkv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,   1, 0, 'h15, 0, 1, 0));
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 'h55, 0, 1, 1));
        add(mkv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,   1, 0, 'h15, 0, 1, 1));
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 'h55, 0, 1, 2));
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,   0, 0, 'hA8, 0, 1, 2));
        add(mkv(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1,   1, 0, 'h55, 0, 2, 2));
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 'h55, 0, 2, 2));

        for (int i = 0; i < table_q.size(); i++) begin
            step(table_q[i]);
        end

        // dmem never ready: timeout every 5th cycle, sticky mem_err, stall counter saturates at 15
        step(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 'h00, 0, 0, 0));
        nst = 0;
        for (int k = 0; k < 22; k++) begin
            v = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,
                    (k % 5 == 4) ? 1 : 0, 0, (k % 5 == 4) ? 'h55 : 'hA8,
                    (k >= 5) ? 1 : 0, nst, 0);
            step(v);
            if ((k % 5 != 4) && (nst < 15)) begin
                nst++;
            end
        end
        // reset in the middle of a wait, then idle must advance from S_RUN
        step(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 'h00, 0, 0, 0));
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 'h55, 0, 0, 0));
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 'h55, 0, 0, 0));

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
